// File: rtl/uart_pkg.sv
// Shared UART transmit types and helpers.
// Used by the LIFO drain FSM and its baud tick generator.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam int UART_DATA_BITS = 8;

  function automatic int baud_w(input int clks);
    return $clog2(clks);
  endfunction

endpackage

// File: rtl/lifo_uart_drain_if.sv
// Read side of the 8x8 LIFO: non-empty flag, top byte, pop strobe.
// master = the drain engine, slave = the LIFO.
interface lifo_uart_drain_if;

  logic       valid;
  logic [7:0] data;
  logic       pop;

  modport master (
    input  valid,
    input  data,
    output pop
  );

  modport slave (
    output valid,
    output data,
    input  pop
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Baud down-counter: tick every CLKS_PER_BIT cycles.
// Reloads on restart so every FSM state gets a full bit period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int W = baud_w(CLKS_PER_BIT);
  localparam logic [W-1:0] RELOAD = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Count down; wrap or reload to the top of the bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (restart || cnt_q == '0) begin
      cnt_d = RELOAD;
    end else begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/lifo_uart_drain.sv
// Drains the LIFO top-first and serialises each byte as UART 8N1.
// Outputs are registered one cycle behind the FSM state.
module lifo_uart_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     drain,
  lifo_uart_drain_if.master        lifo,
  output logic                     tx,
  output logic                     busy,
  output logic                     done,
  output logic [3:0]               sent
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [3:0]     sent_q, sent_d;
  logic           tx_q, tx_d;
  logic           pop_q, pop_d;
  logic           done_q, done_d;
  logic           tick;
  logic           restart;

  // Every state entry starts a fresh bit period.
  assign restart = (state_d != state_q);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // Next-state, datapath and output decode.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    sent_d    = sent_q;
    done_d    = 1'b0;
    pop_d     = 1'b0;
    tx_d      = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (drain) begin
          if (lifo.valid) begin
            sent_d  = '0;
            state_d = LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      LOAD: begin
        shift_d = lifo.data;
        if (sent_q != 4'hF) begin
          sent_d = sent_q + 4'd1;
        end
        state_d = START;
      end
      START: begin
        tx_d = 1'b0;
        if (tick) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (lifo.valid) begin
            state_d = LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    pop_d = (state_q == LOAD);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      sent_q    <= '0;
      tx_q      <= 1'b1;
      pop_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      sent_q    <= sent_d;
      tx_q      <= tx_d;
      pop_q     <= pop_d;
      done_q    <= done_d;
    end
  end

  assign lifo.pop = pop_q;
  assign tx       = tx_q;
  assign done     = done_q;
  assign sent     = sent_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_lifo_uart_drain.sv
// Directed bench for lifo_uart_drain with a behavioural LIFO
// and a UART 8N1 receiver monitor, CLKS_PER_BIT = 4.
module tb_lifo_uart_drain;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       drain = 1'b0;
  logic       tx, busy, done;
  logic [3:0] sent;

  lifo_uart_drain_if lif ();

  lifo_uart_drain #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .drain (drain),
    .lifo  (lif),
    .tx    (tx),
    .busy  (busy),
    .done  (done),
    .sent  (sent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural LIFO: push+pop in one cycle replaces the top.
  logic [7:0]  stk [8];
  logic [3:0]  cnt = 4'd0;
  logic [2:0]  top;
  logic        ld = 1'b0;
  logic [3:0]  ld_n = 4'd0;
  logic [63:0] ld_v = '0;
  logic        push = 1'b0;
  logic [7:0]  push_v = 8'h00;

  assign top = 3'(cnt - 4'd1);
  assign lif.valid = (cnt != 4'd0);
  assign lif.data  = (cnt != 4'd0) ? stk[top] : 8'h00;

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 8; i++) stk[i] <= ld_v[8*i +: 8];
      cnt <= ld_n;
    end else if (lif.pop && push && cnt != 4'd0) begin
      stk[top] <= push_v;
    end else if (lif.pop) begin
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end else if (push && cnt < 4'd8) begin
      stk[cnt[2:0]] <= push_v;
      cnt <= cnt + 4'd1;
    end
  end

  // Event logs sampled on the falling edge.
  int pop_t[$];
  int done_t[$];
  always @(negedge clk) begin
    if (lif.pop === 1'b1) pop_t.push_back(cyc);
    if (done === 1'b1) done_t.push_back(cyc);
  end

  // UART receiver: sample mid-bit, one bit every C negedges.
  int         rx_ph = -1;
  logic [7:0] rx_sh = '0;
  logic       rx_err = 1'b0;
  logic [7:0] rx_q[$];
  bit         rx_eq[$];
  int         rx_t[$];
  always @(negedge clk) begin
    if (rst) begin
      rx_ph <= -1;
    end else if (rx_ph < 0) begin
      if (tx === 1'b0) begin
        rx_ph <= 1;
        rx_t.push_back(cyc);
      end
    end else begin
      rx_ph <= rx_ph + 1;
      if (rx_ph == 2) begin
        rx_err <= (tx !== 1'b0);
      end else if (rx_ph >= 6 && rx_ph <= 34 && rx_ph % 4 == 2) begin
        rx_sh <= {tx, rx_sh[7:1]};
      end else if (rx_ph == 38) begin
        rx_q.push_back(rx_sh);
        rx_eq.push_back(rx_err || tx !== 1'b1);
        rx_ph <= -1;
      end
    end
  end

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    int          n;
    logic [63:0] stk;
    bit          hold;
    int          push_k;
    logic [7:0]  push_v;
    int          nchk;
    logic [63:0] exp;
    int          exp_sent;
    int          exp_pops;
  } vec_t;

  vec_t tv[5];

  initial begin
    int e, pb, rb, db, np, nr;
    bit seen, bad;
    logic [63:0] got;

    tv[0] = '{3, 64'h0000_0000_00A5_2211, 0, -1, 8'h00,
              3, 64'h0000_0000_0011_22A5, 3, 3};
    tv[1] = '{0, 64'h0, 0, -1, 8'h00, 0, 64'h0, 0, 0};
    tv[2] = '{8, 64'h0706_0504_0302_0100, 1, -1, 8'h00,
              8, 64'h0001_0203_0405_0607, 8, 8};
    tv[3] = '{1, 64'h10, 0, 22, 8'h99, 2, 64'h9910, 2, 2};
    tv[4] = '{2, 64'h0201, 0, 2, 8'h77, 2, 64'h7702, -1, -1};

    @(negedge clk);
    @(negedge clk);
    chk("reset_state", {tx, lif.pop, busy, done, sent}, 8'b1000_0000);

    for (int v = 0; v < 5; v++) begin
      rst  = 1'b1;
      ld   = 1'b1;
      ld_v = tv[v].stk;
      ld_n = 4'(tv[v].n);
      @(negedge clk);
      ld  = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      #1;
      pb = pop_t.size();
      rb = rx_q.size();
      db = done_t.size();
      drain = 1'b1;
      @(negedge clk);
      e = cyc;
      chk($sformatf("v%0d_busy_load", v), busy, tv[v].n > 0);
      if (!tv[v].hold) drain = 1'b0;
      seen = 1'b0;
      for (int k = 1; k < 420 && !seen; k++) begin
        #1;
        if (done_t.size() > db) begin
          seen = 1'b1;
        end else begin
          @(negedge clk);
          if (k == tv[v].push_k - 1) begin
            push   = 1'b1;
            push_v = tv[v].push_v;
          end
          if (k == tv[v].push_k) push = 1'b0;
        end
      end
      push = 1'b0;
      chk($sformatf("v%0d_done_seen", v), seen, 1);
      chk($sformatf("v%0d_busy_at_done", v), busy, 0);
      if (tv[v].exp_sent >= 0)
        chk($sformatf("v%0d_sent", v), sent, tv[v].exp_sent);
      if (tv[v].hold) begin
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (busy !== 1'b0) bad = 1'b1;
        end
        chk($sformatf("v%0d_hold_no_restart", v), bad, 0);
        drain = 1'b0;
      end else begin
        repeat (5) @(negedge clk);
        chk($sformatf("v%0d_done_count", v), done_t.size() - db, 1);
      end
      #1;
      np = pop_t.size() - pb;
      nr = rx_q.size() - rb;
      if (tv[v].exp_pops >= 0) begin
        chk($sformatf("v%0d_pops", v), np, tv[v].exp_pops);
        chk($sformatf("v%0d_frames", v), nr, tv[v].exp_pops);
      end
      got = '0;
      for (int i = 0; i < tv[v].nchk && i < nr; i++)
        got[8*i +: 8] = rx_q[rb + i];
      chk($sformatf("v%0d_bytes", v), got, tv[v].exp);
      bad = 1'b0;
      for (int i = 0; i < nr; i++) if (rx_eq[rb + i]) bad = 1'b1;
      chk($sformatf("v%0d_framing", v), bad, 0);
      if (np > 0) begin
        chk($sformatf("v%0d_first_pop", v), pop_t[pb] - e, 1);
        chk($sformatf("v%0d_start_edge", v), rx_t[rb] - e, 2);
        bad = 1'b0;
        for (int i = 1; i < np; i++)
          if (pop_t[pb + i] - pop_t[pb + i - 1] != 41) bad = 1'b1;
        chk($sformatf("v%0d_pop_spacing", v), bad, 0);
        if (done_t.size() > db)
          chk($sformatf("v%0d_done_lag", v),
              done_t[db] - pop_t[pb + np - 1], 40);
      end else if (done_t.size() > db) begin
        chk($sformatf("v%0d_done_next", v), done_t[db] - e, 0);
        chk($sformatf("v%0d_tx_idle", v), tx, 1);
      end
    end

    // Reset in the middle of a DATA bit.
    rst  = 1'b1;
    ld   = 1'b1;
    ld_v = 64'h0000_0000_0011_2233;
    ld_n = 4'd3;
    @(negedge clk);
    ld  = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    drain = 1'b1;
    @(negedge clk);
    e = cyc;
    drain = 1'b0;
    while (cyc < e + 22) @(negedge clk);
    chk("rst_mid_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_out", {tx, busy, lif.pop, sent}, 7'b1000000);
    rst = 1'b0;
    #1;
    pb = pop_t.size();
    bad = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    #1;
    chk("rst_mid_idle", bad, 0);
    chk("rst_mid_no_pop", pop_t.size() - pb, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
